iis_slave_transmitter: RTL
==========================

IIS_SLAVE_TRANSMITTER -- requirements
Module: iis_slave_transmitter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for iis_sck and iis_ws, legal values 2..4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: stereo frames buffered, power of two, legal values 2..16.
REQ-003 SHALL have port mck, input, 1 bit: the single clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port iis_sck, input, 1 bit: external bit clock, asynchronous to mck, period >= 4*SYNC_STAGES mck cycles.
REQ-006 SHALL have port iis_ws, input, 1 bit: external word select; 0 = left slot, 1 = right slot; changes on iis_sck falling edges.
REQ-007 SHALL have port in_left, input, 32 bits signed: left sample.
REQ-008 SHALL have port in_right, input, 32 bits signed: right sample.
REQ-009 SHALL have port in_valid, input, 1 bit: a stereo frame is offered.
REQ-010 SHALL have port in_ready, output, 1 bit: the FIFO can accept a frame.
REQ-011 SHALL have port iis_sd, output, 1 bit: serial data, registered.
REQ-012 SHALL have port locked, output, 1 bit: frame alignment acquired.
REQ-013 SHALL have port underrun, output, 1 bit: one-cycle pulse when a frame is due and the FIFO is empty.

Function
REQ-014 SHALL pass iis_sck and iis_ws through SYNC_STAGES flops, then detect sck_rise and sck_fall as single-mck-cycle pulses from the synchronized sck and its one-cycle-delayed copy.
REQ-015 SHALL sample the synchronized ws on each sck_rise into ws_q and keep the previous sample in ws_qq.
REQ-016 SHALL raise event L_START on the sck_rise where ws_q goes 1->0, and event R_START on the sck_rise where ws_q goes 0->1.
REQ-017 SHALL accept a frame (push {in_left,in_right}) in a cycle with in_valid && in_ready; in_ready = !full, taken combinationally from the registered FIFO count.
REQ-018 SHALL include a state machine with states UNLOCKED and LOCKED; reset enters UNLOCKED, the first L_START moves to LOCKED, and only rst leaves LOCKED; locked = (state == LOCKED).
REQ-019 SHALL, in UNLOCKED, hold iis_sd = 0, perform no pops and no underrun, while still accepting pushes.
REQ-020 SHALL, on every L_START (including the locking one), pop one frame into the shift register (left word) and a right holding register; if the FIFO is empty, it loads 0 into both and pulses underrun for one mck cycle.
REQ-021 SHALL, on R_START, load the right holding register into the shift register.
REQ-022 SHALL provide a one-SCK delay (Philips I2S): the MSB of the loaded word appears on iis_sd at the first sck_fall after the load event, and each later sck_fall shifts left by one bit with 0 filling.
REQ-023 SHALL register iis_sd as shift_reg[31], updated in the mck cycle after sck_fall is detected.
REQ-024 SHALL transmit 0 bits after the LSB when a slot is longer than 32 SCKs, and drop unsent LSBs when a slot is shorter than 32 SCKs; the next start event always reloads.
REQ-025 SHALL have the push take effect and the pop see the pushed frame when a push and a pop coincide on a non-empty FIFO; on an empty FIFO the pop underruns and the push is stored.
REQ-026 SHALL keep the FIFO count in the range 0..FIFO_DEPTH, with pointers wrapping modulo FIFO_DEPTH.
REQ-027 SHALL leave an L_START and an R_START in the same cycle impossible (ws_q is single-valued); an sck_fall coinciding with a load event cannot occur given REQ-005.

Reset
REQ-028 SHALL, on rst, go to UNLOCKED, empty the FIFO, and clear the shift and holding registers and the synchronizers; outputs then read iis_sd=0, locked=0, underrun=0, in_ready=1.
REQ-029 SHALL, on rst asserted mid-frame, produce iis_sd=0 from the next cycle, and require a new L_START to relock.

Verification
REQ-030 SHALL cover basic framing: push L=0x80000001, R=0x7FFFFFFE, then drive 64-SCK frames with mck/sck=8 -> bits after L_START read 1,0...0,1, then 0,1...1,0 after R_START, each MSB one SCK after the ws edge; locked=1.
REQ-031 SHALL cover underrun: lock with an empty FIFO -> underrun pulses once per L_START, iis_sd stays 0, and the next pushed frame is sent at the following L_START.
REQ-032 SHALL cover full FIFO: push 4 frames with no SCK -> in_ready=0 after the 4th; a 5th in_valid is ignored; after one L_START, in_ready=1 and the frames come out in FIFO order.
REQ-033 SHALL cover slot width: 48-SCK frames (24 per slot) with L=0xABCDEF12 -> first 24 bits are 0xABCDEF, the rest truncated; 80-SCK frames -> 32 data bits then 8 zeros.
REQ-034 SHALL cover pre-lock: push frame, start SCK with ws=1 for 40 SCKs -> iis_sd=0 and locked=0 until the first ws 1->0, then the frame is sent.
REQ-035 SHALL cover mid-frame reset: assert rst mid-left-slot -> iis_sd=0, locked=0, in_ready=1 next cycle; relock on the next L_START with underrun=1.

Source files
------------

// File: rtl/iis_slave_transmitter.sv
// Philips I2S slave transmitter: buffers stereo frames and serialises them on the external SCK/WS.
// Load on the WS edge seen at an SCK rise; MSB out at the next SCK fall; in_ready drops when the frame FIFO is full.
module iis_slave_transmitter #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               mck,
  input  logic               rst,
  input  logic               iis_sck,
  input  logic               iis_ws,
  input  logic signed [31:0] in_left,
  input  logic signed [31:0] in_right,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               iis_sd,
  output logic               locked,
  output logic               underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic                   sck_s;
  logic                   ws_s;
  logic                   sck_d;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   rise_d;
  logic                   ws_q;
  logic                   ws_qq;
  logic                   l_start;
  logic                   r_start;

  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [63:0]   head;

  logic [31:0] shift_reg;
  logic [31:0] hold_reg;

  // Edge detection and WS sampling
  always_ff @(posedge mck) begin
    if (rst) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sck_d    <= 1'b0;
      rise_d   <= 1'b0;
      ws_q     <= 1'b0;
      ws_qq    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], iis_sck};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0], iis_ws};
      sck_d    <= sck_s;
      rise_d   <= sck_rise;
      if (sck_rise) begin
        ws_q  <= ws_s;
        ws_qq <= ws_q;
      end
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign ws_s     = ws_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;

  // Events are judged one mck after the rise, once ws_q/ws_qq hold the new and previous samples
  assign l_start = rise_d & ws_qq & ~ws_q;
  assign r_start = rise_d & ~ws_qq & ws_q;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = ~full;
  assign push     = in_valid & in_ready;
  assign pop      = l_start & ~empty;
  assign head     = mem[rd_ptr];

  always_ff @(posedge mck) begin
    if (push) begin
      mem[wr_ptr] <= {in_left, in_right};
    end
  end

  always_ff @(posedge mck) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge mck) begin
    if (rst) begin
      state <= UNLOCKED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      UNLOCKED: if (l_start) state_nxt = LOCKED;
      LOCKED:   state_nxt = LOCKED;
      default:  state_nxt = UNLOCKED;
    endcase
  end

  assign locked = (state == LOCKED);

  // Serialiser: an empty FIFO at L_START sends a silent frame
  always_ff @(posedge mck) begin
    if (rst) begin
      shift_reg <= '0;
      hold_reg  <= '0;
      iis_sd    <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= l_start & empty;
      if (l_start) begin
        shift_reg <= empty ? 32'h0 : head[63:32];
        hold_reg  <= empty ? 32'h0 : head[31:0];
      end else if (r_start && state == LOCKED) begin
        shift_reg <= hold_reg;
      end else if (sck_fall) begin
        shift_reg <= {shift_reg[30:0], 1'b0};
      end
      if (sck_fall) begin
        iis_sd <= (state == LOCKED) ? shift_reg[31] : 1'b0;
      end
    end
  end

endmodule
